// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the serial-to-parallel demultiplexer.
//   DEMUX_WIDTH  : default number of lanes (word width)
//   idx_width()  : lane-index width for a given lane count
//   out_state_e  : output holding-register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;

  // Width of an index that addresses 'width' lanes; never narrower than 1 bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/lane_counter.sv
// -----------------------------------------------------------------------------
// lane_counter
// Modulo-WIDTH up-counter that selects the lane for the next accepted bit.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), wins over i_en
//   i_en    : advance the count by one, wrapping WIDTH-1 -> 0
//   o_idx   : current lane index
// -----------------------------------------------------------------------------
module lane_counter
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_idx;
  logic             w_at_last;

  assign w_at_last = (r_idx == IDX_W'(WIDTH - 1));

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= w_at_last ? '0 : r_idx + 1'b1;
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/demux1to8_sipo.sv
// -----------------------------------------------------------------------------
// demux1to8_sipo
// Receiving end of an 8:1 mux path. Serial bits arrive one per accepted cycle
// in lane order 0..WIDTH-1, are steered into a shadow register, and the full
// word is moved into a holding register offered with a valid/ready handshake.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous clear of the partial word (idx and shadow)
//   din        : serial data bit
//   din_valid  : din is valid this cycle
//   din_ready  : block can accept din this cycle
//   idx        : lane the next accepted bit is written to
//   dout       : assembled word, dout[i] = i-th accepted bit
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer takes dout this cycle
// -----------------------------------------------------------------------------
module demux1to8_sipo
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  logic [IDX_W-1:0] w_idx;
  logic             w_last_lane;
  logic             w_acc;
  logic             w_complete;

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_dout;
  out_state_e       r_state;
  out_state_e       w_state_nxt;

  lane_counter #(
    .WIDTH (WIDTH)
  ) u_lane_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_en  (w_acc),
    .o_idx (w_idx)
  );

  assign w_last_lane = (w_idx == IDX_W'(WIDTH - 1));

  // Only the word-completing bit can stall: it needs the holding register to
  // be free or being drained this same cycle.
  assign din_ready  = ~w_last_lane | (r_state == EMPTY) | dout_ready;
  assign w_acc      = din_valid & din_ready & ~clr;
  assign w_complete = w_acc & w_last_lane;

  // Shadow lanes: clr wipes any partial word; otherwise write only the
  // addressed lane. Stale lanes are simply overwritten by the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (clr) begin
      r_shadow <= '0;
    end else if (w_acc) begin
      r_shadow[w_idx] <= din;
    end
  end

  // Holding register: the completing bit goes straight into the top lane so
  // the word is visible one cycle after its last bit. Unaffected by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_complete) begin
      r_dout <= {din, r_shadow[WIDTH-2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next-state value is defaulted before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_complete) w_state_nxt = FULL;
      end
      FULL: begin
        // A completion in the same cycle as a drain keeps the slot full with
        // the new word: no bubble, no loss.
        if (w_complete)      w_state_nxt = FULL;
        else if (dout_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign idx        = w_idx;
  assign dout       = r_dout;
  assign dout_valid = (r_state == FULL);

endmodule

// File: tb/tb_demux1to8_sipo.sv
// -----------------------------------------------------------------------------
// tb_demux1to8_sipo
// Directed bench for demux1to8_sipo: bit sweep, back-to-back words,
// back-pressure on the completing bit, clr, async reset, gapped input.
// -----------------------------------------------------------------------------
module tb_demux1to8_sipo;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  int n_tests  = 0;
  int n_failed = 0;

  demux1to8_sipo #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .idx        (idx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return #1 after the edge.
  task automatic cyc(input logic v, input logic b, input logic rdy,
                     input logic c);
    din_valid  = v;
    din        = b;
    dout_ready = rdy;
    clr        = c;
    @(posedge clk);
    #1;
  endtask

  // Send all bits of a word with din_valid held high; checks din_ready and
  // idx progression on every bit.
  task automatic send_word(input string tag, input logic [7:0] w,
                           input logic rdy);
    for (int s = 0; s < WIDTH; s++) begin
      din_valid  = 1'b1;
      din        = w[s];
      dout_ready = rdy;
      clr        = 1'b0;
      #1;
      check({tag, "_din_ready"}, din_ready, 1'b1);
      @(posedge clk);
      #1;
      check({tag, "_idx"}, idx, (s + 1) % WIDTH);
    end
  endtask

  logic [7:0] w_gap;

  initial begin
    rst = 1'b1; clr = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_idx", idx, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_dout_valid", dout_valid, 1'b0);

    // Sweep: bits of 10101010, lane by lane, consumer always ready.
    for (int s = 0; s < WIDTH; s++) begin
      cyc(1'b1, (s % 2 == 1), 1'b1, 1'b0);
      check("sweep_idx", idx, (s + 1) % WIDTH);
      check("sweep_valid", dout_valid, (s == WIDTH - 1));
    end
    check("sweep_dout", dout, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("sweep_pulse_end", dout_valid, 1'b0);
    check("sweep_idx_home", idx, 0);

    // Back-to-back A5, 3C with dout_ready held high.
    send_word("b2b_w1", 8'hA5, 1'b1);
    check("b2b_w1_valid", dout_valid, 1'b1);
    check("b2b_w1_dout", dout, 8'hA5);
    send_word("b2b_w2", 8'h3C, 1'b1);
    check("b2b_w2_valid", dout_valid, 1'b1);
    check("b2b_w2_dout", dout, 8'h3C);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_drain", dout_valid, 1'b0);

    // Back-pressure: F0 held, then 96 stalls only on its last bit.
    send_word("bp_w1", 8'hF0, 1'b0);
    check("bp_w1_dout", dout, 8'hF0);
    check("bp_w1_valid", dout_valid, 1'b1);
    for (int s = 0; s < WIDTH - 1; s++) begin
      din_valid = 1'b1; din = s[0] ^ s[1] ^ s[2] ^ (s == 1 || s == 2 || s == 4);
      dout_ready = 1'b0; clr = 1'b0;
      din = (8'h96 >> s) & 1'b1;
      #1;
      check("bp_w2_din_ready", din_ready, 1'b1);
      @(posedge clk);
      #1;
      check("bp_w2_idx", idx, s + 1);
      check("bp_hold_dout", dout, 8'hF0);
    end
    din_valid = 1'b1; din = 1'b1; dout_ready = 1'b0;
    #1;
    check("bp_stall_din_ready", din_ready, 1'b0);
    @(posedge clk);
    #1;
    check("bp_stall_idx", idx, 7);
    check("bp_stall_dout", dout, 8'hF0);
    check("bp_stall_valid", dout_valid, 1'b1);
    dout_ready = 1'b1;
    #1;
    check("bp_release_din_ready", din_ready, 1'b1);
    @(posedge clk);
    #1;
    check("bp_release_dout", dout, 8'h96);
    check("bp_release_valid", dout_valid, 1'b1);
    check("bp_release_idx", idx, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drain", dout_valid, 1'b0);

    // clr after 5 bits drops the same-cycle bit and rewinds idx.
    for (int s = 0; s < 5; s++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_pre_idx", idx, 5);
    din_valid = 1'b1; din = 1'b1; dout_ready = 1'b0; clr = 1'b1;
    #1;
    check("clr_din_ready", din_ready, 1'b1);
    @(posedge clk);
    #1;
    check("clr_idx", idx, 0);
    check("clr_dout_kept", dout, 8'h96);
    send_word("clr_w", 8'h81, 1'b0);
    check("clr_w_dout", dout, 8'h81);
    check("clr_w_valid", dout_valid, 1'b1);

    // clr does not disturb a pending word.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_pend_idx", idx, 0);
    check("clr_pend_valid", dout_valid, 1'b1);
    check("clr_pend_dout", dout, 8'h81);

    // Async reset mid-word with a word pending, checked between edges.
    for (int s = 0; s < 3; s++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("arst_pre_idx", idx, 3);
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_idx", idx, 0);
    check("arst_dout", dout, 8'h00);
    check("arst_valid", dout_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_after_valid", dout_valid, 1'b0);
    check("arst_after_idx", idx, 0);

    // Gapped input: valid every other cycle, junk on the idle cycles.
    w_gap = 8'h5A;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (i % 2 == 0) cyc(1'b1, w_gap[i/2], 1'b1, 1'b0);
      else            cyc(1'b0, ~w_gap[i/2], 1'b1, 1'b0);
      check("gap_idx", idx, ((i / 2) + 1) % WIDTH);
      if (i == 2 * WIDTH - 2) begin
        check("gap_valid", dout_valid, 1'b1);
        check("gap_dout", dout, 8'h5A);
      end
    end
    check("gap_drained", dout_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/demux1to8_sipo.md
Name: demux1to8_sipo

Overview:
- Receiving end of the 8:1 mux path: accepts a serial bit stream, one bit per accepted cycle, in select order 0..WIDTH-1.
- Each bit is routed (demultiplexed) into lane idx of a shadow register.
- When the last lane is written, the full word is transferred to a holding register and presented with a valid/ready handshake.
- Used to rebuild d[] from y when the mux select is swept 0..7.

Parameters:
- WIDTH, 8, number of lanes (output word width); power of two, at least 2.
- IDX_W, $clog2(WIDTH), lane-index width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of the partial word
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept din this cycle
- idx  output  IDX_W  lane the next accepted bit is written to
- dout  output  WIDTH  assembled word; dout[i] = i-th accepted bit
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer takes dout this cycle

Behaviour:
- Reset (async, rst=1): idx=0, shadow=0, dout=0, dout_valid=0. Outputs hold these values until the first clk edge after rst falls.
- Accept condition: acc = din_valid & din_ready & ~clr.
- Routing on acc: shadow[idx] <= din; idx <= idx+1.
  - idx wraps from WIDTH-1 to 0.
  - Other lanes are unchanged.
- Word completion: acc with idx==WIDTH-1.
  - dout <= {din, shadow[WIDTH-2:0]}.
  - dout_valid <= 1.
  - shadow is not cleared; stale lanes are overwritten by the next word.
- Output FSM, two states:
  - EMPTY (dout_valid=0): goes to FULL on word completion.
  - FULL (dout_valid=1): goes to EMPTY on dout_ready with no completion the same cycle.
  - FULL with dout_ready and completion the same cycle: stays FULL and dout takes the new word. No bubble, no loss.
- din_ready (combinational) = (idx != WIDTH-1) | ~dout_valid | dout_ready.
  - Only the completing bit can be back-pressured; lanes 0..WIDTH-2 are always accepted.
- dout is stable while dout_valid=1 and dout_ready=0.
- Latency: word visible on dout/dout_valid the cycle after its last bit is accepted. Sustained throughput is one bit per cycle, one word per WIDTH cycles.
- clr (synchronous): idx <= 0, shadow <= 0.
  - Any din in the same cycle is dropped; clr has priority over accept.
  - dout and dout_valid are not affected; a pending word survives clr.
  - din_ready is not gated by clr.
- rst asserted mid-word or with a word pending: everything returns to reset values immediately, and the pending word is lost.
- din_valid=0: no state change except the dout_ready drain.
- din and dout_ready are sampled only on clk edges. No combinational path from din to dout.

Decomposition:
- Package demux_pkg: DEMUX_WIDTH=8 and the IDX_W derivation function/constant; an enum {EMPTY, FULL} for the output state.
- Sub-module lane_counter (mod-WIDTH up-counter with enable and sync clear) drives idx.
- Shadow, holding register and FSM stay in the top module.

Test Plan:
- Sweep s=0..7 with din=d[s], d=8'b10101010, din_valid=1, dout_ready=1 -> dout=8'b10101010 and a one-cycle dout_valid pulse on the cycle after s=7; idx returns to 0.
- Two back-to-back words, 8'hA5 then 8'h3C, with dout_ready held 1 -> dout_valid high on cycles 9 and 17; dout=A5 then 3C; din_ready never low.
- First word 8'hF0 with dout_ready=0, then the second word's first 7 bits -> all 7 accepted; din_ready=0 at idx=7; dout stays F0. Raise dout_ready -> last bit accepted the same cycle, dout becomes the second word, dout_valid stays 1.
- After 5 bits (idx=5), assert clr with din_valid=1 -> bit dropped, idx=0. The next 8 bits 8'h81 -> dout=8'h81.
- Assert rst asynchronously mid-word (idx=3) with dout_valid=1 -> idx=0, dout=0, dout_valid=0 without waiting for clk.
- Toggle din_valid every other cycle while sending 8'h5A -> dout=8'h5A after exactly 8 accepted bits; idx advances only on valid cycles.
